// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared constants, channel configuration type and divisor clamp
//               for the programmable clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int CLKDIV_MIN_DIV = 2;
    localparam int CLKDIV_IDX_W   = 4;
    // Storage width of a configuration field; the divider WIDTH must not exceed it.
    localparam int CLKDIV_MAX_W   = 32;

    typedef struct packed {
        logic [CLKDIV_MAX_W-1:0] div;
        logic [CLKDIV_MAX_W-1:0] high;
    } chan_cfg_t;

    function automatic logic [CLKDIV_MAX_W-1:0] clamp_div(input logic [CLKDIV_MAX_W-1:0] d);
        return (d < CLKDIV_MAX_W'(CLKDIV_MIN_DIV)) ? CLKDIV_MAX_W'(CLKDIV_MIN_DIV) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_channel
// Description : One divider channel: period counter, shadow/active config and
//               registered clock_out/tick. CLKDIV_PHASE_SYNC_EN adds sync_in.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             chan_en,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_divisor,
    input  logic [WIDTH-1:0] wr_high,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clock_out,
    output logic             tick
);

    localparam chan_cfg_t c_reset_cfg = '{
        div:  CLKDIV_MAX_W'(DEFAULT_DIV),
        high: CLKDIV_MAX_W'(DEFAULT_DIV / 2)
    };

    logic [WIDTH-1:0]        r_cnt;
    chan_cfg_t               r_shadow;
    chan_cfg_t               r_active;
    logic                    r_clock_out;
    logic                    r_tick;

    chan_cfg_t               w_wr_cfg;
    chan_cfg_t               w_load_cfg;
    logic [CLKDIV_MAX_W-1:0] w_cnt_ext;
    logic                    w_restart;

    always_comb begin
        w_wr_cfg.div  = clamp_div(CLKDIV_MAX_W'(wr_divisor));
        w_wr_cfg.high = CLKDIV_MAX_W'(wr_high);
        // A write landing on the restart edge goes straight to the active set.
        w_load_cfg    = wr_en ? w_wr_cfg : r_shadow;
        w_cnt_ext     = CLKDIV_MAX_W'(r_cnt);
        w_restart     = (w_cnt_ext >= (r_active.div - CLKDIV_MAX_W'(1)));
`ifdef CLKDIV_PHASE_SYNC_EN
        w_restart     = w_restart | sync_in;
`endif
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_shadow    <= c_reset_cfg;
            r_active    <= c_reset_cfg;
            r_clock_out <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            if (wr_en) begin
                r_shadow <= w_wr_cfg;
            end
            if (!chan_en) begin
                r_cnt       <= '0;
                r_clock_out <= 1'b0;
                r_tick      <= 1'b0;
                if (wr_en) begin
                    r_active <= w_wr_cfg;
                end
            end else begin
                r_clock_out <= (w_cnt_ext < r_active.high);
                r_tick      <= (r_cnt == '0);
                if (w_restart) begin
                    r_cnt    <= '0;
                    r_active <= w_load_cfg;
                end else begin
                    r_cnt    <= r_cnt + WIDTH'(1);
                end
            end
        end
    end

    assign clock_out = r_clock_out;
    assign tick      = r_tick;

endmodule
`default_nettype wire

// File: rtl/clock_divider_prog.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_prog
// Description : Multi-channel runtime-programmable clock divider with glitch-free
//               reprogramming. CLKDIV_PHASE_SYNC_EN adds a phase-align input.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                    clock_in,
    input  logic                    reset_n,
    input  logic [CHANNELS-1:0]     chan_en,
    input  logic                    wr_en,
    input  logic [CLKDIV_IDX_W-1:0] wr_chan,
    input  logic [WIDTH-1:0]        wr_divisor,
    input  logic [WIDTH-1:0]        wr_high,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic                    sync_in,
`endif
    output logic [CHANNELS-1:0]     clock_out,
    output logic [CHANNELS-1:0]     tick
);

    logic [CHANNELS-1:0] w_wr_hit;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            // Indices at or above CHANNELS match no channel, so such writes drop.
            assign w_wr_hit[i] = wr_en && (wr_chan == CLKDIV_IDX_W'(i));

            clkdiv_channel #(
                .WIDTH       (WIDTH),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_channel (
                .clock_in    (clock_in),
                .reset_n     (reset_n),
                .chan_en     (chan_en[i]),
                .wr_en       (w_wr_hit[i]),
                .wr_divisor  (wr_divisor),
                .wr_high     (wr_high),
`ifdef CLKDIV_PHASE_SYNC_EN
                .sync_in     (sync_in),
`endif
                .clock_out   (clock_out[i]),
                .tick        (tick[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/clock_divider_prog.md
# clock_divider_prog

Multi-channel, runtime-programmable clock divider generating square-wave `clock_out` and a one-cycle `tick` strobe per channel from a single `clock_in`. Each channel has its own divisor and high-time, written through a simple write port and applied only at a period boundary, so reprogramming never produces a glitch or runt pulse. It sits between the board clock and the waveform/LED/display logic, replacing fixed-divisor dividers.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `WIDTH`, 28: counter/divisor/high-time width in bits.
- `DEFAULT_DIV`, 10: divisor loaded into every channel at reset; must be ≥ 2.
- `clock_in`  input  1  system clock; all logic on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `chan_en`  input  CHANNELS  per-channel run enable.
- `wr_en`  input  1  write strobe for the configuration port.
- `wr_chan`  input  4  target channel index.
- `wr_divisor`  input  WIDTH  new divisor (period in `clock_in` cycles).
- `wr_high`  input  WIDTH  new high-time in cycles.
- `clock_out`  output  CHANNELS  divided waveform, registered.
- `tick`  output  CHANNELS  one-cycle pulse at the start of each period, registered.

## Operation
- Per channel state: `cnt`, shadow `div_s`/`high_s`, active `div_a`/`high_a`.
- Reset: `cnt`=0; `div_s`=`div_a`=DEFAULT_DIV; `high_s`=`high_a`=DEFAULT_DIV/2; `clock_out`=0, `tick`=0.
- Write (`wr_en`=1, `wr_chan`<CHANNELS): `div_s`←max(`wr_divisor`,2) (0 and 1 clamp to 2); `high_s`←`wr_high`. Writes with `wr_chan`≥CHANNELS are ignored.
- Running (`chan_en`=1): if `cnt` ≥ `div_a`−1, then `cnt`←0 and `div_a`/`high_a` ← shadow; otherwise `cnt`←`cnt`+1.
- Simultaneous write and wrap on the same channel: the written value bypasses the shadow and becomes active at that wrap.
- Outputs: `clock_out`←(`cnt` < `high_a`); `tick`←(`cnt`==0). Both are computed from the pre-edge `cnt`.
- `high_a`=0 gives a constant 0; `high_a` ≥ `div_a` gives a constant 1. `tick` still pulses once per period in both cases.
- Disabled (`chan_en`=0): `cnt` is held at 0, `clock_out`=0, `tick`=0. A write while disabled updates both shadow and active values immediately.
- Re-enable: the first cycle sees `cnt`=0, so `clock_out` rises (if `high_a`>0) and `tick` pulses one edge after `chan_en` rises.
- Channels are fully independent. No arithmetic exceeds WIDTH bits; `div_a`−1 never underflows because `div_a` ≥ 2.

## Timing
- Latency from `chan_en` rising to the first `tick` is 1 cycle.
- Period is exactly `div_a` cycles; high time is exactly min(`high_a`, `div_a`) cycles.
- A write takes effect at the next wrap: between 1 and `div_a` cycles later.
- Asynchronous reset takes effect immediately mid-period; the first period after release starts at `cnt`=0.
- Everything is single-cycle. There is no backpressure and no handshake beyond `wr_en`.

## Configuration
- `CLKDIV_PHASE_SYNC_EN` defined:
  - Adds input `sync_in` (1 bit).
  - When `sync_in`=1, every enabled channel forces `cnt`←0 and loads its shadow registers, which phase-aligns all channels. That channel's next cycle behaves like cnt=0.
  - `sync_in` takes priority over normal wrap.
- Not defined: port absent; channels free-run from their own enable.

## Structure
- Package `clkdiv_pkg`:
  - `CLKDIV_MIN_DIV`=2.
  - Channel-index width constant.
  - `chan_cfg_t` struct (`div`, `high`).
- Sub-module `clkdiv_channel`: counter, shadow/active registers, and output regs for one channel. The top level instantiates it CHANNELS times and decodes the write port.

## Test plan
- Reset, enable ch0 with defaults → `clock_out[0]` period 10 cycles, high 5; `tick[0]` every 10 cycles, 1 cycle after enable.
- Write ch1 div=4, high=1 mid-period while ch1 runs div=10 → old 10-cycle period completes, then 4-cycle periods with 1 high cycle; no runt pulse.
- Write div=0 or div=1 → behaves as div=2, a 50% square wave at `clock_in`/2 with high=1.
- high=0 → `clock_out` is constant 0; high=12 with div=8 → constant 1; `tick` still pulses every 8 cycles.
- `wr_chan`=CHANNELS → no channel changes. Deassert `chan_en` mid-period → outputs 0 next edge; re-enable → restarts at cnt=0. Assert `reset_n`=0 mid-high → `clock_out` drops asynchronously.
- With `CLKDIV_PHASE_SYNC_EN`: ch0 div=6, ch1 div=9 free-running, pulse `sync_in` → both `tick`s fire on the same cycle one edge later.
